// File: rtl/mem_ctrl_pkg.sv
// Package: mem_ctrl_pkg
// Shared constants and types for the main_mem streaming controller.
//   AM_EN / AM_IDLE : main_mem access-mode encodings (00 = access, 11 = idle)
//   state_t         : controller FSM states
//   *_W_DEF         : default widths matching main_mem (64-bit words, 32 deep)
package mem_ctrl_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 6;

    localparam logic [1:0] AM_EN   = 2'b00;
    localparam logic [1:0] AM_IDLE = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RDW,
        ST_OPS,
        ST_RES,
        ST_WR,
        ST_FIN
    } state_t;

endpackage

// File: rtl/mem_stream_ctrl.sv
// Module: mem_stream_ctrl
// Streams COUNT operand pairs from main_mem to the compute unit and writes
// each result back to main_mem.
//   Pair i is read from src_base+2i / src_base+2i+1 and its result is
//   written to dst_base+i. Addresses wrap modulo 2**ADDR_W.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, src_base, dst_base,
//   count                     job request (sampled only while idle)
//   busy, done                job status; done is a one-cycle pulse
//   R_am, R_addr              main_mem read port (R_am=00 reads)
//   W_am, W_addr, mem_wdata   main_mem write port (W_am=00 writes)
//   mem_rd1, mem_rd2          main_mem read data (R_addr, R_addr+1)
//   op_valid/op_ready, op_a/op_b      operand pair to compute unit
//   res_valid/res_ready, res_data     result from compute unit
// All outputs are registered.
module mem_stream_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        R_am,
    output logic [ADDR_W-1:0] R_addr,
    output logic [1:0]        W_am,
    output logic [ADDR_W-1:0] W_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rd1,
    input  logic [DATA_W-1:0] mem_rd2,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data
);

    state_t            state;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W-1:0] wr_ptr;
    logic [CNT_W-1:0]  remaining;

    // Next read address for the following pair; wraps silently.
    logic [ADDR_W-1:0] rd_ptr_next;
    assign rd_ptr_next = rd_ptr + ADDR_W'(2);

    // NOTE: non-blocking assignments throughout so every register updates
    // from pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            R_am      <= AM_IDLE;
            R_addr    <= '0;
            W_am      <= AM_IDLE;
            W_addr    <= '0;
            mem_wdata <= '0;
            op_valid  <= 1'b0;
            op_a      <= '0;
            op_b      <= '0;
            res_ready <= 1'b0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            remaining <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (count != '0) begin
                            rd_ptr    <= src_base;
                            wr_ptr    <= dst_base;
                            remaining <= count;
                            // Read enable is issued together with the
                            // transition so it is visible during RD.
                            R_am      <= AM_EN;
                            R_addr    <= src_base;
                            state     <= ST_RD;
                        end else begin
                            // Empty job: straight to completion, no access.
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end
                    end
                end

                ST_RD: begin
                    R_am  <= AM_IDLE;
                    state <= ST_RDW;
                end

                ST_RDW: begin
                    // main_mem data for the read issued in RD is valid now.
                    op_a     <= mem_rd1;
                    op_b     <= mem_rd2;
                    op_valid <= 1'b1;
                    state    <= ST_OPS;
                end

                ST_OPS: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        res_ready <= 1'b1;
                        state     <= ST_RES;
                    end
                end

                ST_RES: begin
                    if (res_valid) begin
                        mem_wdata <= res_data;
                        res_ready <= 1'b0;
                        W_am      <= AM_EN;
                        W_addr    <= wr_ptr;
                        state     <= ST_WR;
                    end
                end

                ST_WR: begin
                    // The write lands on the edge leaving WR, before the
                    // next pair's read is sampled by main_mem.
                    W_am      <= AM_IDLE;
                    rd_ptr    <= rd_ptr_next;
                    wr_ptr    <= wr_ptr + ADDR_W'(1);
                    remaining <= remaining - CNT_W'(1);
                    if (remaining == CNT_W'(1)) begin
                        done  <= 1'b1;
                        state <= ST_FIN;
                    end else begin
                        R_am   <= AM_EN;
                        R_addr <= rd_ptr_next;
                        state  <= ST_RD;
                    end
                end

                ST_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Testbench: tb_mem_stream_ctrl
// Drives mem_stream_ctrl against a behavioural main_mem and an adding
// compute unit with programmable handshake stalls. Expected values are
// hand-computed per directed job.
module tb_mem_stream_ctrl;

    localparam int DATA_W = 64;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 6;
    localparam int BUDGET = 200;

    logic              clk;
    logic              rst;
    logic              start;
    logic [ADDR_W-1:0] src_base;
    logic [ADDR_W-1:0] dst_base;
    logic [CNT_W-1:0]  count;
    logic              busy;
    logic              done;
    logic [1:0]        R_am;
    logic [ADDR_W-1:0] R_addr;
    logic [1:0]        W_am;
    logic [ADDR_W-1:0] W_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rd1;
    logic [DATA_W-1:0] mem_rd2;
    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              res_valid;
    logic              res_ready;
    logic [DATA_W-1:0] res_data;

    mem_stream_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .src_base (src_base),
        .dst_base (dst_base),
        .count    (count),
        .busy     (busy),
        .done     (done),
        .R_am     (R_am),
        .R_addr   (R_addr),
        .W_am     (W_am),
        .W_addr   (W_addr),
        .mem_wdata(mem_wdata),
        .mem_rd1  (mem_rd1),
        .mem_rd2  (mem_rd2),
        .op_valid (op_valid),
        .op_ready (op_ready),
        .op_a     (op_a),
        .op_b     (op_b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- main_mem model (synchronous read, wraps 31->0) ----------
    logic [DATA_W-1:0] mem [32];
    logic              tb_we;
    logic [ADDR_W-1:0] tb_waddr;
    logic [DATA_W-1:0] tb_wdata;
    logic [ADDR_W-1:0] r_addr_p1;
    assign r_addr_p1 = R_addr + 5'd1;

    always @(posedge clk) begin
        if (tb_we)
            mem[tb_waddr] <= tb_wdata;
        else if (W_am == 2'b00)
            mem[W_addr] <= mem_wdata;
        if (R_am == 2'b00) begin
            mem_rd1 <= mem[R_addr];
            mem_rd2 <= mem[r_addr_p1];
        end
    end

    // ---------------- compute unit model (res = a + b) ------------------------
    int                op_stall;
    int                res_stall;
    int                op_cnt;
    int                res_cnt;
    logic [DATA_W-1:0] pend;
    logic [DATA_W-1:0] last_a;
    logic [DATA_W-1:0] last_b;

    always @(negedge clk) begin
        if (op_valid) begin
            op_ready = (op_cnt >= op_stall);
            if (op_ready) begin
                pend   = op_a + op_b;
                last_a = op_a;
                last_b = op_b;
            end
            op_cnt++;
        end else begin
            op_ready = 1'b0;
            op_cnt   = 0;
        end
        if (res_ready) begin
            res_valid = (res_cnt >= res_stall);
            res_data  = pend;
            res_cnt++;
        end else begin
            res_valid = 1'b0;
            res_cnt   = 0;
        end
    end

    // ---------------- bus monitors ---------------------------------------------
    int                rd_en_cnt;
    int                wr_en_cnt;
    int                both_en_cnt;
    int                unstable_cnt;
    int                ops_rise_cnt;
    logic              prev_valid;
    logic [DATA_W-1:0] prev_a;
    logic [DATA_W-1:0] prev_b;

    always @(negedge clk) begin
        if (R_am == 2'b00) rd_en_cnt++;
        if (W_am == 2'b00) wr_en_cnt++;
        if (R_am == 2'b00 && W_am == 2'b00) both_en_cnt++;
        if (op_valid && prev_valid && (op_a != prev_a || op_b != prev_b)) unstable_cnt++;
        if (op_valid && !prev_valid) ops_rise_cnt++;
        prev_valid = op_valid;
        prev_a     = op_a;
        prev_b     = op_b;
    end

    // ---------------- checking --------------------------------------------------
    int n_checks;
    int n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    endtask

    // Start a job and wait for done; lat counts cycles including the start cycle.
    task automatic run_job(input logic [ADDR_W-1:0] src, input logic [ADDR_W-1:0] dst,
                           input logic [CNT_W-1:0] cnt, output int lat);
        int cyc;
        @(negedge clk);
        src_base = src;
        dst_base = dst;
        count    = cnt;
        start    = 1'b1;
        cyc      = 0;
        while (cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (done) break;
        end
        start = 1'b0;
        lat   = cyc + 1;
    endtask

    task automatic preload_identity();
        @(negedge clk);
        tb_we = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tb_waddr = ADDR_W'(i);
            tb_wdata = DATA_W'(i);
            @(negedge clk);
        end
        tb_we = 1'b0;
    endtask

    int lat;
    int rd0, wr0, both0, uns0, ops0;
    int cyc;

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        src_base  = '0;
        dst_base  = '0;
        count     = '0;
        tb_we     = 1'b0;
        tb_waddr  = '0;
        tb_wdata  = '0;
        op_ready  = 1'b0;
        res_valid = 1'b0;
        res_data  = '0;
        op_stall  = 0;
        res_stall = 0;
        op_cnt    = 0;
        res_cnt   = 0;
        pend      = '0;
        last_a    = '0;
        last_b    = '0;
        rd_en_cnt = 0;
        wr_en_cnt = 0;
        both_en_cnt = 0;
        unstable_cnt = 0;
        ops_rise_cnt = 0;
        prev_valid = 1'b0;
        prev_a    = '0;
        prev_b    = '0;
        n_checks  = 0;
        n_pass    = 0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_R_am", 64'(R_am), 64'd3);
        check("rst_W_am", 64'(W_am), 64'd3);
        check("rst_op_valid", 64'(op_valid), 64'd0);
        check("rst_res_ready", 64'(res_ready), 64'd0);
        preload_identity();
        rst = 1'b0;

        // ---- 1: basic job, mem[i]=i, src=0 dst=16 count=4 ----
        rd0 = rd_en_cnt; wr0 = wr_en_cnt;
        run_job(5'd0, 5'd16, 6'd4, lat);
        check("t1_latency", 64'(lat), 64'd22);
        check("t1_busy_at_done", 64'(busy), 64'd1);
        check("t1_mem16", mem[16], 64'd1);
        check("t1_mem17", mem[17], 64'd5);
        check("t1_mem18", mem[18], 64'd9);
        check("t1_mem19", mem[19], 64'd13);
        check("t1_rd_enables", 64'(rd_en_cnt - rd0), 64'd4);
        check("t1_wr_enables", 64'(wr_en_cnt - wr0), 64'd4);
        @(negedge clk);
        check("t1_done_pulse", 64'(done), 64'd0);
        check("t1_busy_after", 64'(busy), 64'd0);

        // ---- 2: empty job ----
        rd0 = rd_en_cnt; wr0 = wr_en_cnt;
        run_job(5'd3, 5'd7, 6'd0, lat);
        check("t2_latency", 64'(lat), 64'd2);
        check("t2_done", 64'(done), 64'd1);
        @(negedge clk);
        check("t2_done_pulse", 64'(done), 64'd0);
        check("t2_no_reads", 64'(rd_en_cnt - rd0), 64'd0);
        check("t2_no_writes", 64'(wr_en_cnt - wr0), 64'd0);

        // ---- 3: read wrap, src=31 ----
        run_job(5'd31, 5'd8, 6'd1, lat);
        check("t3_latency", 64'(lat), 64'd7);
        check("t3_op_a", last_a, 64'd31);
        check("t3_op_b", last_b, 64'd0);
        check("t3_mem8", mem[8], 64'd31);

        // ---- 4: handshake stalls ----
        op_stall = 3; res_stall = 4;
        uns0 = unstable_cnt; wr0 = wr_en_cnt;
        run_job(5'd4, 5'd20, 6'd1, lat);
        check("t4_latency", 64'(lat), 64'd14);
        check("t4_op_stable", 64'(unstable_cnt - uns0), 64'd0);
        check("t4_wr_enables", 64'(wr_en_cnt - wr0), 64'd1);
        check("t4_mem20", mem[20], 64'd9);
        op_stall = 0; res_stall = 0;

        // ---- 5a: overlap src=0 dst=1 count=2 ----
        run_job(5'd0, 5'd1, 6'd2, lat);
        check("t5a_latency", 64'(lat), 64'd12);
        check("t5a_mem1", mem[1], 64'd1);
        check("t5a_pair2_a", last_a, 64'd2);
        check("t5a_mem2", mem[2], 64'd5);

        // ---- 5b: overlap where pair 2 reads pair 1's result ----
        run_job(5'd0, 5'd2, 6'd2, lat);
        check("t5b_pair2_a", last_a, 64'd1);
        check("t5b_mem2", mem[2], 64'd1);
        check("t5b_mem3", mem[3], 64'd4);

        // ---- 6: reset during OPS of pair 2 ----
        preload_identity();
        op_stall = 6;
        ops0 = ops_rise_cnt;
        @(negedge clk);
        src_base = 5'd8; dst_base = 5'd24; count = 6'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (ops_rise_cnt - ops0 < 2 && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
        end
        check("t6_reached_ops2", 64'(ops_rise_cnt - ops0), 64'd2);
        rst = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_op_valid", 64'(op_valid), 64'd0);
        check("t6_rst_R_am", 64'(R_am), 64'd3);
        check("t6_rst_W_am", 64'(W_am), 64'd3);
        check("t6_rst_op_a", op_a, 64'd0);
        check("t6_rst_wdata", mem_wdata, 64'd0);
        wr0 = wr_en_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        op_stall = 0;
        repeat (5) @(negedge clk);
        check("t6_no_more_writes", 64'(wr_en_cnt - wr0), 64'd0);
        check("t6_mem24", mem[24], 64'd17);
        check("t6_mem25", mem[25], 64'd25);
        run_job(5'd10, 5'd26, 6'd1, lat);
        check("t6_restart_latency", 64'(lat), 64'd7);
        check("t6_mem26", mem[26], 64'd21);

        // ---- global bus rule: never read and write in the same cycle ----
        check("never_both_enabled", 64'(both_en_cnt), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
